uart_rx_even_parity: RTL and testbench
======================================

Name: uart_rx_even_parity

Overview:
- UART receiver, the far-end counterpart of the board's 11-bit-frame UART transmitter.
- Frame format: start '0', 8 data bits LSB first, even parity bit (= XOR of data), stop '1'.
- Deserialises frames arriving on a board pin and presents the byte with a one-cycle valid strobe plus parity and framing status.
- Sits between the RX pin and downstream consumers, e.g. LED/display logic or a loopback to the TX block.

Parameters:
- CLK_FREQ, 125_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, line bit rate.
- Derived (localparam):
  - DIV = CLK_FREQ / BAUD_RATE (1085 at defaults), integer-truncated.
  - HALF = DIV / 2 (542).
  - Counter width sized for DIV-1.

Ports:
- CLK  input  1  system clock (SYSCLK); all logic on its rising edge.
- RST  input  1  synchronous, active-high reset.
- RXD  input  1  asynchronous serial line, idle high.
- Dout  output  8  last received data byte.
- Valid  output  1  one-cycle pulse: Dout/Parity_err updated.
- Parity_err  output  1  parity status of the frame reported by the last Valid.
- Frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- Busy  output  1  high while a frame is being received.

Behaviour:
- Reset and CLK:
  - One clock, CLK. Reset is synchronous and active-high on RST.
  - On reset: Dout=8'h00, Valid=0, Parity_err=0, Frame_err=0, Busy=0, state=IDLE, counters=0, synchroniser FFs=1.
  - Reset mid-frame aborts immediately. No Valid or Frame_err is produced for the aborted frame.
- Input sync: RXD passes through 2 flip-flops (rx_s). Only rx_s is used internally.
- States and transitions:
  - IDLE: Busy=0. Detect rx_s == 0. The edge where this is first seen is cycle T0. Go to START and clear the baud counter.
  - START: count HALF cycles, then sample rx_s at T0+HALF.
    - If the sample is 1 (glitch): return to IDLE, no outputs.
    - If the sample is 0: go to DATA, bit index=0, counter reload.
  - DATA: sample every DIV cycles, so data bit k is sampled at T0+HALF+(k+1)*DIV.
    - Shift the sample into shift_reg[7] and shift right, giving LSB-first assembly.
    - After bit 7, go to PARITY.
  - PARITY: sample at T0+HALF+9*DIV. Store calc_err = sample XOR (^shift_reg). Go to STOP.
  - STOP: sample at T0+HALF+10*DIV.
    - Stop = 1: on the next edge Dout <= shift_reg, Parity_err <= calc_err, Valid=1 for exactly one cycle, then go to IDLE.
    - Stop = 0: Frame_err=1 for one cycle. Dout and Parity_err are unchanged and there is no Valid. Go to BREAK.
  - BREAK: wait until rx_s == 1, then go to IDLE. A held-low line (break condition) produces only one Frame_err.
- Busy: 1 in START, DATA, PARITY, STOP and BREAK. It drops in the same cycle the FSM enters IDLE.
- Latency: Valid is high in cycle T0+HALF+10*DIV+1, with T0 measured at the synchronised signal (pin edge + 2 cycles).
- Back-to-back frames: a start bit immediately following a stop bit must be caught. IDLE re-arms on the cycle after Valid, which leaves about HALF cycles of margin.
- Dout and Parity_err hold their values until the next successful frame. Parity_err is meaningful only from Valid onward.
- Tolerance: mid-bit sampling tolerates ±4% total baud mismatch. No oversampling or majority vote is used.

Test Plan:
- Use CLK_FREQ=160, BAUD_RATE=10 (DIV=16, HALF=8) for speed, plus one run at the default parameters.
- 'A' byte: drive frame 0x41, parity 0, stop 1 → Valid pulse 1 cycle at T0+8+160+1; Dout=8'h41; Parity_err=0; Frame_err=0; Busy high from T0 until Valid.
- Odd-weight byte: 0x4F with parity 1 → Dout=8'h4F, Parity_err=0. Then 0x41 with parity forced to 1 → Valid, Dout=8'h41, Parity_err=1.
- Framing error: 0x55, correct parity, stop=0, line held low 5 bit times → exactly one Frame_err pulse, no Valid, Dout retains the previous value, Busy=1 until RXD returns high then 0.
- False start: RXD low for 3 cycles then high → FSM returns to IDLE at T0+8, no Valid or Frame_err, Busy pulse only.
- Reset mid-frame: assert RST during data bit 4 of 0x3C → all outputs return to reset values next edge. A following clean 0x31 frame is received correctly.
- Back-to-back: frames 0x41, 0x42, 0x43 with no idle gap at the default parameters → three Valid pulses 11*DIV cycles apart, Dout values in order, all error flags 0.

Source files
------------

// File: rtl/uart_rx_even_parity.sv
// UART receiver for 11-bit frames: start 0, 8 data bits LSB first, even parity, stop 1.
// Samples mid-bit from a start-edge-aligned baud counter; reports byte, parity and framing status.
//
// state  | meaning
// IDLE   | line idle, waiting for synchronised low
// START  | half-bit wait, confirm start bit
// DATA   | sample 8 data bits, one per bit period
// PARITY | sample parity bit, compute parity error
// STOP   | sample stop bit
// DONE   | publish byte (Valid) or flag framing error
// BREAK  | wait for line to return high after a framing error
module uart_rx_even_parity #(
    parameter int CLK_FREQ  = 125_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    output logic [7:0] Dout,
    output logic       Valid,
    output logic       Parity_err,
    output logic       Frame_err,
    output logic       Busy
);
    localparam int DIV   = CLK_FREQ / BAUD_RATE;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE,
        S_BREAK
    } state_t;

    state_t           state, state_nxt;
    logic             rx_meta, rx_s;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift_reg, shift_nxt;
    logic             calc_err, calc_err_nxt;
    logic             stop_ok, stop_ok_nxt;
    logic [7:0]       dout_nxt;
    logic             perr_nxt, valid_nxt, ferr_nxt;
    logic             tick;

    assign tick = (cnt == '0);
    assign Busy = (state != S_IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            calc_err   <= 1'b0;
            stop_ok    <= 1'b0;
            Dout       <= '0;
            Parity_err <= 1'b0;
            Valid      <= 1'b0;
            Frame_err  <= 1'b0;
        end else begin
            rx_meta    <= RXD;
            rx_s       <= rx_meta;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shift_reg  <= shift_nxt;
            calc_err   <= calc_err_nxt;
            stop_ok    <= stop_ok_nxt;
            Dout       <= dout_nxt;
            Parity_err <= perr_nxt;
            Valid      <= valid_nxt;
            Frame_err  <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        bit_idx_nxt  = bit_idx;
        shift_nxt    = shift_reg;
        calc_err_nxt = calc_err;
        stop_ok_nxt  = stop_ok;
        dout_nxt     = Dout;
        perr_nxt     = Parity_err;
        valid_nxt    = 1'b0;
        ferr_nxt     = 1'b0;

        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_nxt = S_START;
                    cnt_nxt   = HALF_M1;
                end
            end
            S_START: begin
                if (!tick) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (rx_s) begin
                    state_nxt = S_IDLE;      // glitch shorter than half a bit
                end else begin
                    state_nxt   = S_DATA;
                    cnt_nxt     = DIV_M1;
                    bit_idx_nxt = '0;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    shift_nxt   = {rx_s, shift_reg[7:1]};
                    cnt_nxt     = DIV_M1;
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (!tick) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    calc_err_nxt = rx_s ^ (^shift_reg);
                    cnt_nxt      = DIV_M1;
                    state_nxt    = S_STOP;
                end
            end
            S_STOP: begin
                if (!tick) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    stop_ok_nxt = rx_s;
                    state_nxt   = S_DONE;
                end
            end
            S_DONE: begin
                if (stop_ok) begin
                    dout_nxt  = shift_reg;
                    perr_nxt  = calc_err;
                    valid_nxt = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    ferr_nxt  = 1'b1;
                    state_nxt = S_BREAK;
                end
            end
            S_BREAK: begin
                // a held-low line must not re-trigger a new frame
                if (rx_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_rx_even_parity.sv
// Directed bench for uart_rx_even_parity: a fast instance (DIV=16) for function and
// a default-parameter instance for back-to-back frames.
module tb_uart_rx_even_parity;
    localparam int F_DIV  = 16;
    localparam int F_HALF = 8;
    localparam int S_DIV  = 1085;
    localparam int S_HALF = 542;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd_f, rxd_s;
    logic [7:0] dout_f, dout_s;
    logic       valid_f, perr_f, ferr_f, busy_f;
    logic       valid_s, perr_s, ferr_s, busy_s;

    uart_rx_even_parity #(.CLK_FREQ(160), .BAUD_RATE(10)) u_fast (
        .CLK(clk), .RST(rst), .RXD(rxd_f), .Dout(dout_f), .Valid(valid_f),
        .Parity_err(perr_f), .Frame_err(ferr_f), .Busy(busy_f)
    );

    uart_rx_even_parity u_slow (
        .CLK(clk), .RST(rst), .RXD(rxd_s), .Dout(dout_s), .Valid(valid_s),
        .Parity_err(perr_s), .Frame_err(ferr_s), .Busy(busy_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int nval_f   = 0;
    int nferr_f  = 0;
    int nbusy_f  = 0;
    int last_val_f = 0;
    int nferr_s  = 0;
    int         sval_cyc[$];
    logic [7:0] sval_dout[$];
    logic       sval_perr[$];
    int frame_n;

    always @(negedge clk) begin
        if (valid_f) begin
            nval_f++;
            last_val_f = cyc;
        end
        if (ferr_f) nferr_f++;
        if (busy_f) nbusy_f++;
        if (valid_s) begin
            sval_cyc.push_back(cyc);
            sval_dout.push_back(dout_s);
            sval_perr.push_back(perr_s);
        end
        if (ferr_s) nferr_s++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic hold(input bit slow, input logic v, input int ncyc);
        if (slow) rxd_s = v;
        else      rxd_f = v;
        repeat (ncyc) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit slow, input logic [7:0] d, input logic par,
                              input logic stop, input int stop_len);
        int div;
        div = slow ? S_DIV : F_DIV;
        frame_n = cyc;
        hold(slow, 1'b0, div);
        for (int i = 0; i < 8; i++) hold(slow, d[i], div);
        hold(slow, par, div);
        hold(slow, stop, stop_len);
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, e0, b0, n0;
        rst   = 1'b1;
        rxd_f = 1'b1;
        rxd_s = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_dout",  32'(dout_f), 32'h00);
        check("rst_valid", 32'(valid_f), 32'h0);
        check("rst_perr",  32'(perr_f), 32'h0);
        check("rst_ferr",  32'(ferr_f), 32'h0);
        check("rst_busy",  32'(busy_f), 32'h0);
        check("rst_busy_slow", 32'(busy_s), 32'h0);
        hold(0, 1'b1, 2 * F_DIV);

        // 'A', correct parity: Valid at T0+HALF+10*DIV+1 with T0 = drive edge + 3
        v0 = nval_f; e0 = nferr_f; b0 = nbusy_f;
        send_frame(0, 8'h41, 1'b0, 1'b1, F_DIV);
        hold(0, 1'b1, 2 * F_DIV);
        check("a_valid_cnt", nval_f - v0, 1);
        check("a_latency",   last_val_f - frame_n, 3 + F_HALF + 10 * F_DIV + 1);
        check("a_dout",      32'(dout_f), 32'h41);
        check("a_perr",      32'(perr_f), 32'h0);
        check("a_ferr_cnt",  nferr_f - e0, 0);
        check("a_busy_len",  nbusy_f - b0, F_HALF + 10 * F_DIV + 1);

        v0 = nval_f;
        send_frame(0, 8'h4F, 1'b1, 1'b1, F_DIV);
        hold(0, 1'b1, 2 * F_DIV);
        check("odd_valid_cnt", nval_f - v0, 1);
        check("odd_dout",      32'(dout_f), 32'h4F);
        check("odd_perr",      32'(perr_f), 32'h0);

        v0 = nval_f;
        send_frame(0, 8'h41, 1'b1, 1'b1, F_DIV);
        hold(0, 1'b1, 2 * F_DIV);
        check("bad_par_valid_cnt", nval_f - v0, 1);
        check("bad_par_dout",      32'(dout_f), 32'h41);
        check("bad_par_perr",      32'(perr_f), 32'h1);

        // stop bit low and line held low for 5 bit times in total
        v0 = nval_f; e0 = nferr_f; b0 = nbusy_f;
        send_frame(0, 8'h55, 1'b0, 1'b0, 5 * F_DIV);
        hold(0, 1'b1, 2 * F_DIV);
        check("ferr_cnt",       nferr_f - e0, 1);
        check("ferr_valid_cnt", nval_f - v0, 0);
        check("ferr_dout_kept", 32'(dout_f), 32'h41);
        check("ferr_perr_kept", 32'(perr_f), 32'h1);
        check("ferr_busy_len",  nbusy_f - b0, 3 + 15 * F_DIV - 3);
        check("ferr_busy_end",  32'(busy_f), 32'h0);

        v0 = nval_f; e0 = nferr_f; b0 = nbusy_f;
        hold(0, 1'b0, 3);
        hold(0, 1'b1, 3 * F_DIV);
        check("glitch_busy_len",  nbusy_f - b0, F_HALF);
        check("glitch_valid_cnt", nval_f - v0, 0);
        check("glitch_ferr_cnt",  nferr_f - e0, 0);

        // reset in the middle of data bit 4 of 0x3C
        v0 = nval_f; e0 = nferr_f;
        hold(0, 1'b0, F_DIV);
        for (int i = 0; i < 4; i++) hold(0, 1'(8'h3C >> i), F_DIV);
        hold(0, 1'b1, F_DIV / 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_dout",  32'(dout_f), 32'h00);
        check("mid_rst_perr",  32'(perr_f), 32'h0);
        check("mid_rst_busy",  32'(busy_f), 32'h0);
        check("mid_rst_valid", 32'(valid_f), 32'h0);
        rst = 1'b0;
        hold(0, 1'b1, 3 * F_DIV);
        check("mid_rst_no_valid", nval_f - v0, 0);
        check("mid_rst_no_ferr",  nferr_f - e0, 0);
        send_frame(0, 8'h31, 1'b1, 1'b1, F_DIV);
        hold(0, 1'b1, 2 * F_DIV);
        check("post_rst_valid_cnt", nval_f - v0, 1);
        check("post_rst_dout",      32'(dout_f), 32'h31);
        check("post_rst_perr",      32'(perr_f), 32'h0);

        // default parameters, three frames with no idle gap
        n0 = cyc;
        send_frame(1, 8'h41, 1'b0, 1'b1, S_DIV);
        send_frame(1, 8'h42, 1'b0, 1'b1, S_DIV);
        send_frame(1, 8'h43, 1'b1, 1'b1, S_DIV);
        hold(1, 1'b1, 2 * S_DIV);
        check("b2b_valid_cnt", sval_cyc.size(), 3);
        check("b2b_ferr_cnt",  nferr_s, 0);
        if (sval_cyc.size() == 3) begin
            check("b2b_latency0", sval_cyc[0] - n0, 3 + S_HALF + 10 * S_DIV + 1);
            check("b2b_gap01",    sval_cyc[1] - sval_cyc[0], 11 * S_DIV);
            check("b2b_gap12",    sval_cyc[2] - sval_cyc[1], 11 * S_DIV);
            check("b2b_dout0",    32'(sval_dout[0]), 32'h41);
            check("b2b_dout1",    32'(sval_dout[1]), 32'h42);
            check("b2b_dout2",    32'(sval_dout[2]), 32'h43);
            check("b2b_perr",     32'({sval_perr[0], sval_perr[1], sval_perr[2]}), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
